// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and types for the keypad quantity-entry block.
//   KEY_CLEAR/KEY_BACK/KEY_ENTER : command key codes; 0x0-0x9 are digits,
//                                  0xC/0xD/0xF are ignored.
//   entry_state_e                : entry FSM state encoding.
//   bcd_digit_t / BCD_W          : one BCD digit.
package keypad_pkg;

  localparam int BCD_W = 4;
  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t KEY_CLEAR = 4'hA;
  localparam bcd_digit_t KEY_BACK  = 4'hB;
  localparam bcd_digit_t KEY_ENTER = 4'hE;

  typedef enum logic {
    ST_ENTRY = 1'b0,
    ST_HOLD  = 1'b1
  } entry_state_e;

  function automatic logic is_digit(input bcd_digit_t code);
    return code <= 4'h9;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: turns the raw scanner level/code into one event per physical press.
//   CLK, RST     : clock, asynchronous active-high reset
//   key_code     : raw key code (meaningful while key_pressed=1)
//   key_pressed  : raw key-down level
//   evt_valid    : one-cycle pulse, a press was accepted
//   evt_code     : code of the accepted press (valid with evt_valid)
//   waiting      : 1 after an accepted press until the key has been released
//                  stably for DEBOUNCE_CYCLES cycles
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       key_code,
  input  logic             key_pressed,
  output logic             evt_valid,
  output logic [3:0]       evt_code,
  output logic             waiting
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic             wait_q, wait_d;
  logic             evt_q, evt_d;
  // A key held across reset must be released before it can produce an event.
  logic             seen_rel_q, seen_rel_d;
  logic [CNT_W-1:0] run;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q      <= '0;
      code_q     <= '0;
      wait_q     <= 1'b0;
      evt_q      <= 1'b0;
      seen_rel_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      wait_q     <= wait_d;
      evt_q      <= evt_d;
      seen_rel_q <= seen_rel_d;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    code_d     = code_q;
    wait_d     = wait_q;
    evt_d      = 1'b0;
    seen_rel_d = seen_rel_q | ~key_pressed;
    // Length of the current stable-press run including this cycle.
    run        = (cnt_q != '0 && key_code == code_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);

    if (wait_q) begin
      if (key_pressed) begin
        cnt_d = '0;
      end else if (cnt_q + CNT_W'(1) == CNT_TARGET) begin
        cnt_d  = '0;
        wait_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (key_pressed && seen_rel_q) begin
      code_d = key_code;
      if (run == CNT_TARGET) begin
        evt_d  = 1'b1;
        wait_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = run;
      end
    end else begin
      cnt_d = '0;
    end
  end

  assign evt_valid = evt_q;
  assign evt_code  = code_q;  // holds the accepted code while evt_q is high
  assign waiting   = wait_q;

endmodule

// File: rtl/keypad_qty_entry.sv
// keypad_qty_entry: debounced keypad -> decimal quantity entry -> valid/ready hand-off.
//   CLK, RST     : clock, asynchronous active-high reset
//   key_code     : raw key code from the scanner
//   key_pressed  : raw key-down level from the scanner
//   qty_bcd      : entry buffer, BCD, least-significant digit in [3:0]
//   digit_count  : digits currently entered
//   qty_bin      : binary value of qty_bcd
//   qty_valid    : confirmed quantity offered to the dispenser
//   qty_ready    : dispenser accepts qty_bin this cycle
//   err_pulse    : one-cycle pulse on a rejected ENTER or a digit into a full buffer
//   busy         : waiting for key release, or holding a confirmed quantity
//   state_o      : debug view of the entry FSM state
// Handshake: qty_valid rises only on an accepted ENTER and stays high, with
// qty_bcd/qty_bin frozen, until a cycle where qty_valid & qty_ready; on the
// following edge the buffer clears and qty_valid drops.
module keypad_qty_entry
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS      = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_QTY         = 500,
  parameter int QTY_W           = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [3:0]              key_code,
  input  logic                    key_pressed,
  output logic [4*NUM_DIGITS-1:0] qty_bcd,
  output logic [2:0]              digit_count,
  output logic [QTY_W-1:0]        qty_bin,
  output logic                    qty_valid,
  input  logic                    qty_ready,
  output logic                    err_pulse,
  output logic                    busy,
  output entry_state_e            state_o
);

  localparam int BUF_W = BCD_W * NUM_DIGITS;

  entry_state_e     state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             evt_valid;
  logic [3:0]       evt_code;
  logic             waiting;
  logic [QTY_W-1:0] bin_acc;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK        (CLK),
    .RST        (RST),
    .key_code   (key_code),
    .key_pressed(key_pressed),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .waiting    (waiting)
  );

  // BCD -> binary: Horner evaluation from the most-significant digit down.
  always_comb begin
    bin_acc = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      bin_acc = bin_acc * QTY_W'(10) + QTY_W'(buf_q[i*BCD_W +: BCD_W]);
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_ENTRY;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_ENTRY: begin
        if (evt_valid) begin
          if (is_digit(evt_code)) begin
            if (cnt_q < 3'(NUM_DIGITS)) begin
              buf_d = (buf_q << BCD_W) | BUF_W'(evt_code);
              cnt_d = cnt_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else if (evt_code == KEY_CLEAR) begin
            buf_d = '0;
            cnt_d = '0;
          end else if (evt_code == KEY_BACK) begin
            if (cnt_q != '0) begin
              buf_d = buf_q >> BCD_W;
              cnt_d = cnt_q - 3'd1;
            end
          end else if (evt_code == KEY_ENTER) begin
            if (cnt_q == '0 || bin_acc == '0 || bin_acc > QTY_W'(MAX_QTY)) begin
              err_d = 1'b1;
              buf_d = '0;
              cnt_d = '0;
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
      end
      ST_HOLD: begin
        // Key events are dropped here; only the transfer moves us on.
        if (qty_ready) begin
          state_d = ST_ENTRY;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // Outputs
  always_comb begin
    qty_bcd     = buf_q;
    digit_count = cnt_q;
    qty_bin     = bin_acc;
    qty_valid   = (state_q == ST_HOLD);
    err_pulse   = err_q;
    busy        = (state_q == ST_HOLD) | waiting;
    state_o     = state_q;
  end

endmodule
